// File: rtl/wb_write_arbiter_pkg.sv
// rtl/wb_write_arbiter_pkg.sv - shared register-file widths and writeback source encoding
//   XLEN     : register width
//   REG_AW   : register address width
//   NUM_REGS : architectural register count
//   ZERO_REG : hardwired-zero register address; writes to it are dropped
package wb_write_arbiter_pkg;

    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
    localparam int REG_AW   = $clog2(NUM_REGS);

    localparam logic [REG_AW-1:0] ZERO_REG = '0;

    // Which requester owns the register-file write port this cycle.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_FIFO = 2'd2
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - long-unit result queue with per-entry valid and address-match kill
//   clk, reset            : clock, async active-low reset
//   push, push_waddr/wdata: enqueue one result
//   pop                   : drop the head entry (written or not)
//   kill, kill_addr       : invalidate every valid entry targeting kill_addr
//   head_valid/waddr/wdata: head entry
//   empty, full, count    : occupancy (invalidated entries still occupy a slot)
import wb_write_arbiter_pkg::*;

module wb_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [REG_AW-1:0]            push_waddr,
    input  logic [XLEN-1:0]              push_wdata,
    input  logic                         pop,
    input  logic                         kill,
    input  logic [REG_AW-1:0]            kill_addr,
    output logic                         head_valid,
    output logic [REG_AW-1:0]            head_waddr,
    output logic [XLEN-1:0]              head_wdata,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH):0]       count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0]  valid_q;
    logic [REG_AW-1:0] addr_q [DEPTH];
    logic [XLEN-1:0]   data_q [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    assign head_valid = valid_q[rd_ptr];
    assign head_waddr = addr_q[rd_ptr];
    assign head_wdata = data_q[rd_ptr];
    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));

    // Payload needs no reset: it is only observed through valid_q.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= push_waddr;
            data_q[wr_ptr] <= push_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill && valid_q[i] && (addr_q[i] == kill_addr)) begin
                    valid_q[i] <= 1'b0;
                end
            end
            if (pop) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + PW'(1);
            end
            // A result arriving in the same cycle the pipeline writes its
            // register is older than that write, so it is enqueued dead.
            if (push) begin
                valid_q[wr_ptr] <= !(kill && (push_waddr == kill_addr));
                wr_ptr          <= wr_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// rtl/wb_write_arbiter.sv - register-file write port arbiter: pipeline vs long-latency unit
//   clk, reset                     : clock, async active-low reset
//   pipe_we/pipe_waddr/pipe_wdata  : in-order pipeline writeback (highest priority)
//   lu_valid/lu_waddr/lu_wdata     : long-unit result, accepted when lu_ready
//   lu_ready                       : combinational, result buffer not full
//   we/waddr/wdata                 : registered register-file write
//   stall_req                      : registered, ask upstream to hold pipe_we
//   lu_pending                     : buffer occupancy saturating at 3
import wb_write_arbiter_pkg::*;

module wb_write_arbiter #(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pipe_we,
    input  logic [REG_AW-1:0] pipe_waddr,
    input  logic [XLEN-1:0]   pipe_wdata,
    input  logic              lu_valid,
    input  logic [REG_AW-1:0] lu_waddr,
    input  logic [XLEN-1:0]   lu_wdata,
    output logic              lu_ready,
    output logic              we,
    output logic [REG_AW-1:0] waddr,
    output logic [XLEN-1:0]   wdata,
    output logic              stall_req,
    output logic [1:0]        lu_pending
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic              fifo_empty;
    logic              fifo_full;
    logic [CW-1:0]     fifo_count;
    logic              head_valid;
    logic [REG_AW-1:0] head_waddr;
    logic [XLEN-1:0]   head_wdata;
    logic              pipe_ok;
    logic              lu_push;
    wb_src_e           src;
    logic [SW-1:0]     starve_cnt;
    logic [SW-1:0]     starve_next;

    assign pipe_ok  = pipe_we && (pipe_waddr != ZERO_REG);
    // Gated by reset so nothing is acknowledged while the buffer is held clear.
    assign lu_ready = reset && !fifo_full;
    assign lu_push  = lu_valid && lu_ready && (lu_waddr != ZERO_REG);

    assign lu_pending = (fifo_count >= CW'(3)) ? 2'd3 : fifo_count[1:0];

    always_comb begin
        src = SRC_NONE;
        if (pipe_ok) begin
            src = SRC_PIPE;
        end else if (!fifo_empty) begin
            src = SRC_FIFO;
        end
    end

    // Popping a killed head is still a FIFO grant: the slot made progress.
    always_comb begin
        starve_next = starve_cnt;
        if (fifo_empty || (src == SRC_FIFO)) begin
            starve_next = '0;
        end else if (starve_cnt < SW'(STARVE_LIMIT)) begin
            starve_next = starve_cnt + SW'(1);
        end
    end

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (lu_push),
        .push_waddr (lu_waddr),
        .push_wdata (lu_wdata),
        .pop        (src == SRC_FIFO),
        .kill       (pipe_ok),
        .kill_addr  (pipe_waddr),
        .head_valid (head_valid),
        .head_waddr (head_waddr),
        .head_wdata (head_wdata),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .count      (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we         <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            stall_req  <= 1'b0;
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_next;
            stall_req  <= (starve_cnt == SW'(STARVE_LIMIT));
            case (src)
                SRC_PIPE: begin
                    we    <= 1'b1;
                    waddr <= pipe_waddr;
                    wdata <= pipe_wdata;
                end
                SRC_FIFO: begin
                    we <= head_valid;
                    if (head_valid) begin
                        waddr <= head_waddr;
                        wdata <= head_wdata;
                    end
                end
                default: we <= 1'b0;
            endcase
        end
    end

endmodule
